pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline-boundary register with a valid/ready handshake, stall back-pressure, flush and saturating stall/flush event counters. It replaces the fixed-field ID/EX style stage registers of the pipelined MIPS core with one reusable block. It is instantiated at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with the widths of that boundary. An optional skid buffer breaks the combinational ready path.

## Interface
Parameters:
- DATA_W, 32, width of the datapath payload (pc, operands, immediate, instruction)
- CTRL_W, 16, width of the control payload (write enables, selects, alu_ctrl)
- CNT_W, 16, width of each event counter
- CLEAR_DATA, 1, 1: flush and reset zero out_data; 0: out_data holds its value

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream stage holds a valid instruction
- in_ready  out  1  this stage accepts in_data/in_ctrl this cycle
- in_data  in  DATA_W  payload from upstream
- in_ctrl  in  CTRL_W  control from upstream
- flush  in  1  kill all held and incoming instructions
- out_valid  out  1  out_data/out_ctrl hold a valid instruction
- out_ready  in  1  downstream stage consumes this cycle
- out_data  out  DATA_W  registered payload
- out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0
- clr_cnt  in  1  synchronous clear of both counters
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  out  CNT_W  valid entries killed by flush, saturating

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Reset (rst_n=0, asynchronous): out_valid=0, out_ctrl=0, out_data=0, counters=0, skid empty. in_ready=0 while in reset, 1 on the first cycle after.
- Without skid: in_ready = !flush && (out_ready || !out_valid). On a transfer in, the main register loads the input and out_valid becomes 1. On a transfer out with no transfer in, out_valid becomes 0 and out_ctrl is zeroed. Otherwise the register holds (stall).
- Flush has priority over every other event. On the next edge out_valid=0 and out_ctrl=0, and out_data=0 if CLEAR_DATA. Incoming data is not accepted because in_ready=0.
- out_ctrl is forced to zero whenever out_valid=0, so a bubble carries no write enables.
- stall_cnt increments by 1 on each stall cycle (out_valid && !out_ready) and holds at 2^CNT_W-1.
- flush_cnt adds the number of valid entries killed by a flush (0, 1 or 2) and saturates at 2^CNT_W-1.
- If clr_cnt and an increment occur in the same cycle, clr_cnt wins and the counter becomes 0.

## Timing
- Latency: 1 cycle from transfer in to out_valid=1.
- Throughput: 1 instruction per cycle while out_ready=1.
- in_ready depends combinationally on out_ready and flush, except when skid is enabled.
- Simultaneous transfer in and transfer out on a full register: load the new entry, out_valid stays 1.
- Flush asserted for multiple cycles keeps the stage empty for all of those cycles. The first accept is possible on the cycle after flush deasserts.
- Reset asserted mid-stall drops the held entry immediately, asynchronously.

## Configuration
- PIPE_STAGE_SKID_EN defined: a second skid entry is added and in_ready becomes a registered signal, equal to "skid empty".
  - Skid states: EMPTY (no entries valid), ONE (main valid), TWO (main and skid valid).
  - EMPTY → ONE on transfer in.
  - ONE → TWO on transfer in with !out_ready.
  - ONE → EMPTY on transfer out with no transfer in.
  - TWO → ONE on out_ready; the skid entry moves to main.
  - Any state → EMPTY on flush, with flush_cnt += number of valid entries.
  - Order is preserved in every transition.
- PIPE_STAGE_SKID_EN undefined: single entry, with in_ready combinational as described in Operation. flush_cnt never adds more than 1.

## Structure
- Shared package pipe_pkg:
  - per-boundary width constants (ID_EX_DATA_W, ID_EX_CTRL_W, etc.)
  - packed control-struct typedefs per boundary, e.g. id_ex_ctrl_t with alu_ctrl, alu_src, we_reg, we_dm, dm2reg, mult_we; CTRL_W is taken from the $bits of these structs
  - the counter saturation helper function
- One sub-module, pipe_sat_cnt: a saturating counter with clear and a 0–2 increment, instantiated twice.

## Test plan
- Reset with rst_n=0 while in_valid=1 → out_valid=0, out_ctrl=0, stall_cnt=0, flush_cnt=0; in_ready=1 one cycle after release.
- Stream of 8 entries, in_data = 0x100..0x107, with out_ready=1 → out_data 0x100..0x107 in order, 1-cycle latency, no gaps.
- out_ready=0 for 5 cycles with 1 entry held → out_data stable, in_ready=0, stall_cnt=5.
- flush while an entry is held and in_valid=1 with in_ctrl=0xFFFF → next cycle out_valid=0, out_ctrl=0, flush_cnt=1, input not accepted.
- With CNT_W=4: 20 stall cycles → stall_cnt=15; then clr_cnt → 0.
- With PIPE_STAGE_SKID_EN: drop out_ready while 2 entries (0xA, 0xB) arrive → in_ready=0 next cycle; after release, out_data=0xA then 0xB; flush in state TWO → flush_cnt=2.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, control-struct typedefs and helpers for the pipeline-boundary registers.
// Optional skid buffer in pipe_stage_reg is enabled with the PIPE_STAGE_SKID_EN macro.
package pipe_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic       we_pc;
    } if_id_ctrl_t;

    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic       reg_dst;
        logic       we_reg;
        logic       we_dm;
        logic       dm2reg;
        logic       mult_we;
        logic       branch;
        logic       jump;
        logic       jal;
        logic       jr;
        logic [1:0] hilo_sel;
        logic       shift_sel;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic we_reg;
        logic we_dm;
        logic dm2reg;
        logic jal;
        logic mult_we;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic we_reg;
        logic dm2reg;
        logic jal;
        logic mult_we;
    } mem_wb_ctrl_t;

    // pc_plus4 + instr / pc + rd1 + rd2 + imm + instr / alu_out + wd_dm + pc_plus4 / rd_dm + alu_out + pc_plus4
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_DATA_W  = 160;
    localparam int EX_MEM_DATA_W = 96;
    localparam int MEM_WB_DATA_W = 96;

    localparam int IF_ID_CTRL_W  = $bits(if_id_ctrl_t);
    localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

    // Add 0..3 to a counter of up to 32 bits, clamping at max_val.
    function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                            input logic [1:0]  inc,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {31'd0, inc};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter with synchronous clear and a 0..2 increment per cycle.
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    // Clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc != 2'd0) begin
            cnt <= CNT_W'(sat_add(32'(cnt), inc, 32'(CNT_ONES)));
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline-boundary register: valid/ready handshake, flush, stall/flush counters.
// Define PIPE_STAGE_SKID_EN to add a skid entry and make in_ready a registered signal.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = ID_EX_CTRL_W,
    parameter int CNT_W      = 16,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    skid_state_e       state;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              xfer_in, xfer_out;
    logic              load_main_in, load_main_skid, load_skid;
    logic [1:0]        held_cnt;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID_EN = 1'b1;
    assign in_ready = rst_n && (state != SKID_TWO);
`else
    localparam bit SKID_EN = 1'b0;
    assign in_ready = rst_n && !flush && (out_ready || !out_valid);
`endif

    assign out_valid = (state != SKID_EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;

    // With the skid entry in_ready ignores flush, so a flushed accept is dropped here.
    assign xfer_in        = in_valid && in_ready && !flush;
    assign xfer_out       = out_valid && out_ready;
    assign load_main_in   = xfer_in && ((state == SKID_EMPTY) || (state == SKID_ONE && out_ready));
    assign load_skid      = SKID_EN && xfer_in && (state == SKID_ONE) && !out_ready;
    assign load_main_skid = !flush && (state == SKID_TWO) && out_ready;
    assign held_cnt       = {state == SKID_TWO, state == SKID_ONE};

    // Occupancy and control payload; control is kept zero for every empty entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SKID_EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            state     <= SKID_EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            case (state)
                SKID_EMPTY: if (load_main_in) state <= SKID_ONE;
                SKID_ONE: begin
                    if (load_skid)               state <= SKID_TWO;
                    else if (xfer_out && !xfer_in) state <= SKID_EMPTY;
                end
                SKID_TWO:   if (load_main_skid) state <= SKID_ONE;
                default:    state <= SKID_EMPTY;
            endcase
            if (load_main_in)              main_ctrl <= in_ctrl;
            else if (load_main_skid)       main_ctrl <= skid_ctrl;
            else if (xfer_out && !xfer_in) main_ctrl <= '0;
            if (load_skid)                 skid_ctrl <= in_ctrl;
            else if (load_main_skid)       skid_ctrl <= '0;
        end
    end

    // Payload path: cleared on reset/flush only when CLEAR_DATA, otherwise it simply holds.
    generate
        if (CLEAR_DATA) begin : g_data_clr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_data <= '0;
                    skid_data <= '0;
                end else if (flush) begin
                    main_data <= '0;
                    skid_data <= '0;
                end else begin
                    if (load_main_in)        main_data <= in_data;
                    else if (load_main_skid) main_data <= skid_data;
                    if (load_skid)           skid_data <= in_data;
                end
            end
        end else begin : g_data_hold
            always_ff @(posedge clk) begin
                if (load_main_in)        main_data <= in_data;
                else if (load_main_skid) main_data <= skid_data;
                if (load_skid)           skid_data <= in_data;
            end
        end
    endgenerate

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   ({1'b0, out_valid && !out_ready}),
        .cnt   (stall_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (flush ? held_cnt : 2'd0),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int DATA_W  = 32;
    localparam int CTRL_W  = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, flush, out_valid, out_ready, clr_cnt;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W), .CLEAR_DATA(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .clr_cnt(clr_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } ent_t;

    ent_t              q[$];
    int                exp_stall, exp_flush;
    logic [DATA_W-1:0] hold_data;
    int                n_cmp = 0;
    int                n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    function automatic logic model_ready(input logic fl, input logic orr);
`ifdef PIPE_STAGE_SKID_EN
        return (q.size() < DEPTH);
`else
        return !fl && (orr || q.size() == 0);
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        exp_stall = 0;
        exp_flush = 0;
        hold_data = '0;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, ".out_valid"}, out_valid, q.size() != 0);
        chk({pfx, ".out_data"},  out_data,  q.size() != 0 ? q[0].d : hold_data);
        chk({pfx, ".out_ctrl"},  out_ctrl,  q.size() != 0 ? q[0].c : '0);
        chk({pfx, ".stall_cnt"}, stall_cnt, exp_stall);
        chk({pfx, ".flush_cnt"}, flush_cnt, exp_flush);
    endtask

    // One clock: drive at the falling edge, check in_ready, advance model, check outputs after the rising edge.
    task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic orr, input logic fl, input logic clr);
        logic rdy, acc;
        int   s_add, f_add;
        @(negedge clk);
        in_valid = iv; in_data = d; in_ctrl = c; out_ready = orr; flush = fl; clr_cnt = clr;
        #1;
        rdy = model_ready(fl, orr);
        chk("in_ready", in_ready, rdy);
        acc   = iv && rdy && !fl;
        s_add = (q.size() != 0 && !orr) ? 1 : 0;
        f_add = fl ? q.size() : 0;
        if (fl) begin
            q.delete();
            hold_data = '0;
        end else begin
            if (q.size() != 0 && orr) begin
                hold_data = q[0].d;
                void'(q.pop_front());
            end
            if (acc) q.push_back('{d: d, c: c});
        end
        if (clr) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            exp_stall = sat(exp_stall + s_add);
            exp_flush = sat(exp_flush + f_add);
        end
        @(posedge clk);
        #1;
        check_outputs("step");
    endtask

    task automatic release_reset();
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready_after", in_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_ctrl = 16'hFFFF;
        out_ready = 1'b1; flush = 1'b0; clr_cnt = 1'b0;
        model_reset();
        #1;
        chk("rst.in_ready", in_ready, 1'b0);
        check_outputs("rst");
        repeat (2) @(posedge clk);
        #1;
        check_outputs("rst_hold");
        release_reset();

        // Back-to-back stream.
        for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + i, 16'h0010 + 16'(i), 1'b1, 1'b0, 1'b0);
        chk("stream.last", out_data, 32'h107);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("stream.drained", out_valid, 1'b0);

        // Five stall cycles with an entry held.
        step(1'b1, 32'h200, 16'h0A0A, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + i, 16'h0B0B, 1'b0, 1'b0, 1'b0);
        chk("stall.cnt5", stall_cnt, 4'd5);
        chk("stall.data", out_data, 32'h200);

        // Flush a single held entry while upstream offers data.
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h400, 16'h1234, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h401, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        chk("flush.valid", out_valid, 1'b0);
        chk("flush.ctrl", out_ctrl, 16'h0);
        chk("flush.cnt1", flush_cnt, 4'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush.not_accepted", out_valid, 1'b0);

        // Counter saturation then clear.
        step(1'b1, 32'h500, 16'h0505, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("sat.stall15", stall_cnt, 4'd15);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("sat.clr", stall_cnt, 4'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

`ifdef PIPE_STAGE_SKID_EN
        // Two entries land while downstream is stalled, then drain in order.
        step(1'b1, 32'hA, 16'h000A, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hB, 16'h000B, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 16'h000C, 1'b0, 1'b0, 1'b0);
        chk("skid.head_a", out_data, 32'hA);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("skid.head_b", out_data, 32'hB);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hA, 16'h000A, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hB, 16'h000B, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("skid.flush2", flush_cnt, 4'd2);
`endif

        // Randomised traffic with occasional flush and clear.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom, 16'($urandom), ($urandom % 3) != 0,
                 ($urandom % 20) == 0, ($urandom % 40) == 0);
        end

        // Asynchronous reset in the middle of a stall.
        step(1'b1, 32'h700, 16'h7777, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h701, 16'h7778, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        release_reset();
        step(1'b1, 32'h800, 16'h0808, 1'b1, 1'b0, 1'b0);
        chk("post_rst.data", out_data, 32'h800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
